nco_hop_ctrl: RTL and testbench
===============================

NCO_HOP_CTRL -- requirements
Module: nco_hop_ctrl

Interface
REQ-001 SHALL have parameter APR, default 32, meaning the phase-word width and matching the NCO phi_inc_i/freq_mod_i width.
REQ-002 SHALL have parameter SYMW, default 2, meaning the symbol width; the offset table holds 2**SYMW entries.
REQ-003 SHALL have parameter CNTW, default 16, meaning the width of the symbol-duration counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port clken, input, 1 bit: the same clock enable as the NCO; state advances only when it is high.
REQ-007 SHALL have port cfg_we, input, 1 bit: offset-table write strobe.
REQ-008 SHALL have port cfg_addr, input, SYMW bits: offset-table write index.
REQ-009 SHALL have port cfg_data, input, APR bits: offset-table write data.
REQ-010 SHALL have port carrier_i, input, APR bits: carrier phase increment.
REQ-011 SHALL have port sym_len_i, input, CNTW bits: clken cycles per symbol.
REQ-012 SHALL have port sym_valid, input, 1 bit: symbol-stream valid.
REQ-013 SHALL have port sym_data, input, SYMW bits: symbol value.
REQ-014 SHALL have port sym_ready, output, 1 bit: symbol-stream ready.
REQ-015 SHALL have port nco_valid, input, 1 bit: connected to the NCO out_valid.
REQ-016 SHALL have port phi_inc_o, output, APR bits: drives the NCO phi_inc_i.
REQ-017 SHALL have port freq_mod_o, output, APR bits: drives the NCO freq_mod_i.
REQ-018 SHALL have port busy, output, 1 bit: high in state RUN.
REQ-019 SHALL have port underrun, output, 1 bit: one-cycle pulse when the symbol stream starves.

Function
REQ-020 SHALL implement states WAIT_NCO, IDLE and RUN; reset enters WAIT_NCO.
REQ-021 SHALL move WAIT_NCO -> IDLE on the first clken cycle with nco_valid=1, and SHALL never return to WAIT_NCO except through reset.
REQ-022 SHALL drive sym_ready=0 in WAIT_NCO, SHALL drive sym_ready=1 in IDLE, and SHALL drive sym_ready=1 in RUN only when cnt==0; sym_ready is combinational from state and cnt.
REQ-023 SHALL define accept as sym_valid & sym_ready & clken; sym_data is consumed only on accept.
REQ-024 SHALL, on accept, register freq_mod_o <= table[sym_data], load cnt <= max(sym_len_i,1)-1 and enter or stay in RUN.
REQ-025 SHALL update freq_mod_o one clk after accept, giving 1-cycle latency; back-to-back symbols have no gap cycle.
REQ-026 SHALL decrement cnt on each clken cycle in RUN while cnt>0.
REQ-027 SHALL, in RUN with cnt==0, clken=1 and no accept, go to IDLE, set freq_mod_o <= 0 and pulse underrun for one clk.
REQ-028 SHALL register phi_inc_o <= carrier_i on every clken cycle in WAIT_NCO and IDLE, and SHALL hold phi_inc_o constant in RUN.
REQ-029 SHALL, when clken=0, hold all state, cnt and outputs, force underrun to 0, and make no accept.
REQ-030 SHALL write table[cfg_addr] <= cfg_data when cfg_we=1, independent of clken and state.
REQ-031 SHALL make a table write take effect at the next accept, leaving the current freq_mod_o unchanged.
REQ-032 SHALL, when a write and an accept address the same entry in the same cycle, use the old table value for the accept.
REQ-033 SHALL treat sym_len_i=0 identically to sym_len_i=1.
REQ-034 SHALL sample sym_len_i only at accept.
REQ-035 SHALL treat freq_mod_o as two's complement and SHALL store table entries unmodified, with no arithmetic in this block.

Reset
REQ-036 SHALL, while reset_n=0, asynchronously force state=WAIT_NCO, cnt=0, phi_inc_o=0, freq_mod_o=0, underrun=0 and busy=0, giving sym_ready=0.
REQ-037 SHALL reset all table entries to 0.
REQ-038 SHALL make a reset mid-symbol abandon the symbol and require nco_valid again before the next accept.

Structure
REQ-039 SHALL take the state encoding (WAIT_NCO=2'd0, IDLE=2'd1, RUN=2'd2) and the default parameter values from a shared package nco_ctrl_pkg.
REQ-040 SHALL place the offset table in one sub-module, nco_hop_tbl (register file, one write port, one asynchronous read port, async active-low reset).
REQ-041 SHALL instantiate no other sub-module.

Verification
REQ-042 SHALL cover startup: reset released with nco_valid=0 for 10 clken cycles then 1 -> sym_ready stays 0 until the cycle after nco_valid rises, then is 1.
REQ-043 SHALL cover the FSK run: table={0,0x100,0x200,0x300}, sym_len_i=4, symbols 1,3,2 back-to-back -> freq_mod_o is 0x100, 0x300, 0x200 for exactly 4 clken cycles each, busy=1 throughout.
REQ-044 SHALL cover underrun: a single symbol 2 with sym_len_i=3 -> after 3 cycles freq_mod_o=0, underrun pulses once, state IDLE, sym_ready=1.
REQ-045 SHALL cover clken gating: clken toggling 1/0 with sym_len_i=2 -> each symbol lasts 2 enabled cycles (4 clk) and underrun never asserts with clken=0.
REQ-046 SHALL cover the write collision: cfg_we to entry 1 with 0xABC in the same cycle as accepting symbol 1 (old value 0x100) -> freq_mod_o=0x100; the next symbol 1 gives 0xABC.
REQ-047 SHALL cover mid-run reset: reset_n pulsed low during RUN -> all outputs 0 immediately, sym_ready=0 until nco_valid=1 again.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO frequency-hop controller: defaults and FSM encoding.
package nco_ctrl_pkg;

    localparam int APR_DEF  = 32;
    localparam int SYMW_DEF = 2;
    localparam int CNTW_DEF = 16;

    typedef enum logic [1:0] {
        WAIT_NCO = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2
    } hop_state_e;

endpackage

// File: rtl/nco_hop_ctrl_if.sv
// Offset-table configuration write port shared by the controller and its table.
interface nco_hop_ctrl_if
    import nco_ctrl_pkg::*;
#(
    parameter int APR  = APR_DEF,
    parameter int SYMW = SYMW_DEF
);
    logic            we;
    logic [SYMW-1:0] addr;
    logic [APR-1:0]  data;

    modport master (output we, output addr, output data);
    modport slave  (input  we, input  addr, input  data);
endinterface

// File: rtl/nco_hop_tbl.sv
// Per-symbol frequency-offset register file: one write port, one asynchronous read port.
module nco_hop_tbl
    import nco_ctrl_pkg::*;
#(
    parameter int APR  = APR_DEF,
    parameter int SYMW = SYMW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nco_hop_ctrl_if.slave        wr,
    input  logic [SYMW-1:0]      rd_addr,
    output logic [APR-1:0]       rd_data
);

    localparam int DEPTH = 2 ** SYMW;

    logic [APR-1:0] mem_q [DEPTH];
    logic [APR-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (wr.we) mem_d[wr.addr] = wr.data;
    end

    // NOTE: the table is small and must read as zero after reset, so every
    // entry gets an explicit reset value instead of being left uninitialised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Read comes from the registered array, so a same-cycle write is not visible yet.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nco_hop_ctrl.sv
// Symbol-driven frequency-hop controller feeding an NCO's phi_inc_i / freq_mod_i.
module nco_hop_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int APR  = APR_DEF,
    parameter int SYMW = SYMW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clken,
    input  logic             cfg_we,
    input  logic [SYMW-1:0]  cfg_addr,
    input  logic [APR-1:0]   cfg_data,
    input  logic [APR-1:0]   carrier_i,
    input  logic [CNTW-1:0]  sym_len_i,
    input  logic             sym_valid,
    input  logic [SYMW-1:0]  sym_data,
    output logic             sym_ready,
    input  logic             nco_valid,
    output logic [APR-1:0]   phi_inc_o,
    output logic [APR-1:0]   freq_mod_o,
    output logic             busy,
    output logic             underrun
);

    hop_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [APR-1:0]  phi_q, phi_d;
    logic [APR-1:0]  fm_q, fm_d;
    logic            und_q, und_d;

    logic [APR-1:0]  tbl_rd;
    logic [CNTW-1:0] len_m1;
    logic            accept;

    nco_hop_ctrl_if #(.APR(APR), .SYMW(SYMW)) cfg_bus ();

    assign cfg_bus.we   = cfg_we;
    assign cfg_bus.addr = cfg_addr;
    assign cfg_bus.data = cfg_data;

    nco_hop_tbl #(.APR(APR), .SYMW(SYMW)) u_tbl (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (cfg_bus.slave),
        .rd_addr (sym_data),
        .rd_data (tbl_rd)
    );

    assign sym_ready = (state_q == IDLE) || ((state_q == RUN) && (cnt_q == '0));
    assign accept    = sym_valid && sym_ready && clken;
    // A zero length behaves as a one-cycle symbol.
    assign len_m1    = (sym_len_i == '0) ? '0 : sym_len_i - CNTW'(1);

    // NOTE: every variable gets a hold value first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        fm_d    = fm_q;
        und_d   = und_q;
        if (clken) begin
            und_d = 1'b0;
            case (state_q)
                WAIT_NCO: begin
                    phi_d = carrier_i;
                    if (nco_valid) state_d = IDLE;
                end
                IDLE: phi_d = carrier_i;
                RUN: begin
                    if (!accept) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNTW'(1);
                        end else begin
                            state_d = IDLE;
                            fm_d    = '0;
                            und_d   = 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_NCO;
            endcase
            if (accept) begin
                fm_d    = tbl_rd;
                cnt_d   = len_m1;
                state_d = RUN;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the pre-edge values of each other, matching real hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_NCO;
            cnt_q   <= '0;
            phi_q   <= '0;
            fm_q    <= '0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            fm_q    <= fm_d;
            und_q   <= und_d;
        end
    end

    assign phi_inc_o  = phi_q;
    assign freq_mod_o = fm_q;
    assign busy       = (state_q == RUN);
    // The pulse is held across disabled cycles and shown on the next enabled one.
    assign underrun   = und_q && clken;

endmodule

// File: tb/tb_nco_hop_ctrl.sv
// Directed self-checking bench for nco_hop_ctrl with hand-computed expectations.
module tb_nco_hop_ctrl;

    localparam int APR  = 32;
    localparam int SYMW = 2;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            clken;
    logic [APR-1:0]  carrier_i;
    logic [CNTW-1:0] sym_len_i;
    logic            sym_valid;
    logic [SYMW-1:0] sym_data;
    logic            sym_ready;
    logic            nco_valid;
    logic [APR-1:0]  phi_inc_o;
    logic [APR-1:0]  freq_mod_o;
    logic            busy;
    logic            underrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [APR-1:0] exp_phi;

    nco_hop_ctrl_if #(.APR(APR), .SYMW(SYMW)) cfg_if ();

    nco_hop_ctrl #(.APR(APR), .SYMW(SYMW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clken      (clken),
        .cfg_we     (cfg_if.we),
        .cfg_addr   (cfg_if.addr),
        .cfg_data   (cfg_if.data),
        .carrier_i  (carrier_i),
        .sym_len_i  (sym_len_i),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .nco_valid  (nco_valid),
        .phi_inc_o  (phi_inc_o),
        .freq_mod_o (freq_mod_o),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [SYMW-1:0] a, input logic [APR-1:0] d);
        cfg_if.we = 1'b1; cfg_if.addr = a; cfg_if.data = d;
        tick();
        cfg_if.we = 1'b0;
    endtask

    // Called just after an accept edge with clken=1: checks the symbol's
    // eff enabled cycles, then sets up the next symbol or stops the stream.
    task automatic sym_hold(input logic [APR-1:0] exp_fm, input int eff,
                            input bit more, input logic [SYMW-1:0] nxt,
                            input logic [CNTW-1:0] nlen);
        for (int k = 0; k < eff; k++) begin
            check("hold_fm", freq_mod_o, exp_fm);
            check("hold_busy", busy, 1'b1);
            check("hold_ready", sym_ready, (k == eff - 1));
            check("hold_underrun", underrun, 1'b0);
            check("hold_phi", phi_inc_o, exp_phi);
            if (k == eff - 1) begin
                if (more) begin
                    sym_data = nxt; sym_len_i = nlen;
                end else begin
                    sym_valid = 1'b0;
                end
            end
            tick();
        end
    endtask

    task automatic check_underrun_idle(input string tag);
        check({tag, "_underrun"}, underrun, 1'b1);
        check({tag, "_fm0"}, freq_mod_o, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, sym_ready, 1'b1);
        tick();
        check({tag, "_pulse_end"}, underrun, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; clken = 1'b1; nco_valid = 1'b0;
        carrier_i = 32'h1234; sym_len_i = '0; sym_valid = 1'b0; sym_data = '0;
        cfg_if.we = 1'b0; cfg_if.addr = '0; cfg_if.data = '0;
        #12;
        check("rst_ready", sym_ready, 1'b0);
        check("rst_phi", phi_inc_o, '0);
        check("rst_fm", freq_mod_o, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);

        // Startup: 10 enabled cycles without nco_valid.
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wait_ready", sym_ready, 1'b0);
        end
        check("wait_phi_track", phi_inc_o, 32'h1234);
        nco_valid = 1'b1;
        #1;
        check("wait_ready_same_cycle", sym_ready, 1'b0);
        tick();
        check("idle_ready", sym_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        cfg_write(2'd0, 32'h000);
        cfg_write(2'd1, 32'h100);
        cfg_write(2'd2, 32'h200);
        cfg_write(2'd3, 32'h300);
        check("cfg_no_fm_change", freq_mod_o, '0);

        // FSK run, phi frozen while busy.
        exp_phi = 32'h1234;
        sym_valid = 1'b1; sym_data = 2'd1; sym_len_i = 16'd4;
        tick();
        carrier_i = 32'h9999;
        sym_hold(32'h100, 4, 1'b1, 2'd3, 16'd4);
        sym_hold(32'h300, 4, 1'b1, 2'd2, 16'd4);
        sym_hold(32'h200, 4, 1'b0, 2'd0, 16'd0);
        check_underrun_idle("fsk_end");
        check("idle_phi_track", phi_inc_o, 32'h9999);
        exp_phi = 32'h9999;

        // Single symbol, length 3.
        sym_valid = 1'b1; sym_data = 2'd2; sym_len_i = 16'd3;
        tick();
        sym_hold(32'h200, 3, 1'b0, 2'd0, 16'd0);
        check_underrun_idle("udr");

        // Length 0 behaves as length 1.
        sym_valid = 1'b1; sym_data = 2'd3; sym_len_i = 16'd0;
        tick();
        sym_hold(32'h300, 1, 1'b0, 2'd0, 16'd0);
        check_underrun_idle("len0");

        // Clock-enable gating: symbols 3 then 1, length 2, clken alternating.
        sym_valid = 1'b1; sym_data = 2'd3; sym_len_i = 16'd2;
        tick();
        for (int i = 0; i < 8; i++) begin
            clken = i[0];
            #1;
            check("gate_fm", freq_mod_o, (i < 4) ? 32'h300 : 32'h100);
            check("gate_ready", sym_ready, (i % 4) >= 2);
            check("gate_busy", busy, 1'b1);
            check("gate_underrun", underrun, 1'b0);
            if (i == 2) sym_data = 2'd1;
            if (i == 7) sym_valid = 1'b0;
            tick();
        end
        clken = 1'b0;
        #1;
        check("gate_udr_masked", underrun, 1'b0);
        check("gate_fm0", freq_mod_o, '0);
        check("gate_idle", busy, 1'b0);
        tick();
        clken = 1'b1;
        #1;
        check("gate_udr_shown", underrun, 1'b1);
        tick();
        check("gate_udr_end", underrun, 1'b0);

        // Write collision: same-cycle write to entry 1 uses the old value.
        sym_valid = 1'b1; sym_data = 2'd1; sym_len_i = 16'd1;
        cfg_if.we = 1'b1; cfg_if.addr = 2'd1; cfg_if.data = 32'hABC;
        tick();
        cfg_if.we = 1'b0;
        sym_hold(32'h100, 1, 1'b1, 2'd1, 16'd1);
        sym_hold(32'hABC, 1, 1'b0, 2'd0, 16'd0);
        check_underrun_idle("coll");

        // Mid-run reset abandons the symbol and re-arms the nco_valid wait.
        sym_valid = 1'b1; sym_data = 2'd3; sym_len_i = 16'd10;
        tick();
        check("mr_busy", busy, 1'b1);
        check("mr_fm", freq_mod_o, 32'h300);
        tick();
        nco_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mr_rst_fm", freq_mod_o, '0);
        check("mr_rst_phi", phi_inc_o, '0);
        check("mr_rst_busy", busy, 1'b0);
        check("mr_rst_ready", sym_ready, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_wait_ready", sym_ready, 1'b0);
            check("mr_wait_busy", busy, 1'b0);
        end
        nco_valid = 1'b1;
        tick();
        check("mr_idle_ready", sym_ready, 1'b1);
        tick();
        check("mr_tbl_cleared", freq_mod_o, '0);
        check("mr_rerun_busy", busy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
